icache_burst: RTL

ICACHE_BURST -- requirements
Module: icache_burst

---
 rtl/icache_burst.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/icache_burst.sv
// rtl/icache_burst.sv - set-associative instruction cache with zero-cycle hits and burst line refill
// Tags, data and valid bits live in flops so a hit can be answered in the request cycle.
module icache_burst #(
   parameter int LINE_WIDTH = 128,
   parameter int WORD_WIDTH = 32,
   parameter int NUM_WAYS   = 4,
   parameter int NUM_SETS   = 64,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpu_req_i,
   input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
   output logic                  cpu_valid_o,
   output logic [WORD_WIDTH-1:0] cpu_inst_o,
   input  logic                  flush_i,
   output logic                  flush_busy_o,
   output logic                  mem_req_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   input  logic                  mem_gnt_i,
   input  logic                  mem_valid_i,
   input  logic [WORD_WIDTH-1:0] mem_inst_i
);
   localparam int BEATS = LINE_WIDTH / WORD_WIDTH;
   localparam int OFF_W = $clog2(BEATS);
   localparam int IDX_W = $clog2(NUM_SETS);
   localparam int WAY_W = $clog2(NUM_WAYS);
   localparam int LSB_W = 2 + OFF_W;
   localparam int TAG_W = ADDR_WIDTH - LSB_W - IDX_W;

   typedef enum logic [2:0] {S_IDLE, S_MISS, S_REFILL, S_UPDATE, S_FLUSH} state_t;

   state_t                               r_state;
   logic [NUM_SETS-1:0][NUM_WAYS-1:0]    r_valid;
   logic [NUM_SETS-1:0][WAY_W-1:0]       r_rr;
   logic [TAG_W-1:0]                     r_tags [NUM_SETS][NUM_WAYS];
   logic [LINE_WIDTH-1:0]                r_data [NUM_SETS][NUM_WAYS];
   logic [LINE_WIDTH-1:0]                r_line;
   logic [OFF_W-1:0]                     r_beat;
   logic [TAG_W-1:0]                     r_tag;
   logic [IDX_W-1:0]                     r_idx;
   logic [OFF_W-1:0]                     r_off;
   logic [ADDR_WIDTH-1:0]                r_mem_addr;
   logic                                 r_flush_pend;
   logic [IDX_W-1:0]                     r_flush_idx;

   logic [OFF_W-1:0]                     w_req_off;
   logic [IDX_W-1:0]                     w_req_idx;
   logic [TAG_W-1:0]                     w_req_tag;
   logic                                 w_hit;
   logic [WAY_W-1:0]                     w_hit_way;
   logic [LINE_WIDTH-1:0]                w_hit_line;
   logic                                 w_has_inv;
   logic [WAY_W-1:0]                     w_victim;
   logic                                 w_unused;

   assign w_req_off  = cpu_addr_i[2 +: OFF_W];
   assign w_req_idx  = cpu_addr_i[LSB_W +: IDX_W];
   assign w_req_tag  = cpu_addr_i[ADDR_WIDTH-1 -: TAG_W];
   assign w_hit_line = r_data[w_req_idx][w_hit_way];
   assign w_unused   = ^cpu_addr_i[1:0];

   // Descending scan so the lowest matching way wins.
   always_comb begin
      w_hit     = 1'b0;
      w_hit_way = '0;
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         if (r_valid[w_req_idx][w] && r_tags[w_req_idx][w] == w_req_tag) begin
            w_hit     = 1'b1;
            w_hit_way = WAY_W'(w);
         end
      end
   end

   always_comb begin
      w_has_inv = 1'b0;
      w_victim  = r_rr[r_idx];
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         if (!r_valid[r_idx][w]) begin
            w_has_inv = 1'b1;
            w_victim  = WAY_W'(w);
         end
      end
   end

   // With a flush queued, UPDATE hands the word straight from the line buffer,
   // since the next cycle goes to FLUSH instead of back to IDLE.
   always_comb begin
      cpu_valid_o = 1'b0;
      cpu_inst_o  = '0;
      if (r_state == S_IDLE && cpu_req_i && w_hit) begin
         cpu_valid_o = 1'b1;
         cpu_inst_o  = w_hit_line[w_req_off*WORD_WIDTH +: WORD_WIDTH];
      end else if (r_state == S_UPDATE && r_flush_pend) begin
         cpu_valid_o = 1'b1;
         cpu_inst_o  = r_line[r_off*WORD_WIDTH +: WORD_WIDTH];
      end
   end

   assign mem_req_o    = (r_state == S_MISS);
   assign mem_addr_o   = mem_req_o ? r_mem_addr : '0;
   assign flush_busy_o = r_flush_pend || (r_state == S_FLUSH);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_valid      <= '0;
         r_rr         <= '0;
         r_beat       <= '0;
         r_flush_pend <= 1'b0;
         r_flush_idx  <= '0;
         r_mem_addr   <= '0;
         r_tag        <= '0;
         r_idx        <= '0;
         r_off        <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (flush_i || r_flush_pend) begin
                  r_state      <= S_FLUSH;
                  r_flush_pend <= 1'b0;
                  r_flush_idx  <= '0;
               end else if (cpu_req_i && !w_hit) begin
                  r_state    <= S_MISS;
                  r_tag      <= w_req_tag;
                  r_idx      <= w_req_idx;
                  r_off      <= w_req_off;
                  r_mem_addr <= {cpu_addr_i[ADDR_WIDTH-1:LSB_W], {LSB_W{1'b0}}};
               end
            end
            S_MISS: begin
               if (flush_i) r_flush_pend <= 1'b1;
               if (mem_gnt_i) r_state <= S_REFILL;
            end
            S_REFILL: begin
               if (flush_i) r_flush_pend <= 1'b1;
               if (mem_valid_i) begin
                  r_line[r_beat*WORD_WIDTH +: WORD_WIDTH] <= mem_inst_i;
                  if (r_beat == OFF_W'(BEATS - 1)) begin
                     r_beat  <= '0;
                     r_state <= S_UPDATE;
                  end else begin
                     r_beat <= r_beat + OFF_W'(1);
                  end
               end
            end
            S_UPDATE: begin
               r_valid[r_idx][w_victim] <= 1'b1;
               if (!w_has_inv) r_rr[r_idx] <= r_rr[r_idx] + WAY_W'(1);
               if (r_flush_pend) begin
                  r_state      <= S_FLUSH;
                  r_flush_pend <= 1'b0;
                  r_flush_idx  <= '0;
               end else begin
                  r_state <= S_IDLE;
                  if (flush_i) r_flush_pend <= 1'b1;
               end
            end
            S_FLUSH: begin
               r_valid[r_flush_idx] <= '0;
               r_rr[r_flush_idx]    <= '0;
               if (r_flush_idx == IDX_W'(NUM_SETS - 1)) r_state <= S_IDLE;
               else r_flush_idx <= r_flush_idx + IDX_W'(1);
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && r_state == S_UPDATE) begin
         r_data[r_idx][w_victim] <= r_line;
         r_tags[r_idx][w_victim] <= r_tag;
      end
   end
endmodule
